seven_segment_reader: RTL and testbench

- Receive-side counterpart of the seven-segment decoder: observes a time-multiplexed seven-segment display bus (segment lines plus one-hot digit select) and recovers the displayed BCD digits.
- Qualifies each digit's pattern for stability, reverse-maps segment patterns to digit values and assembles a full multi-digit frame.
- Emits a one-cycle frame_valid pulse per completed frame.
- Used as the loopback checker and scoreboard front-end for display driver blocks.

---
 rtl/seven_segment_reader.sv | 166 ++++++++++++++++
 tb/tb_seven_segment_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
// Recovers BCD digits from a time-multiplexed seven-segment bus and emits one frame per full set of captures.
// Build option SEVEN_SEG_ACTIVE_LOW_EN: treat seg as active-low (common-anode); dig_sel stays active-high.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no stable one-hot select is being observed
// QUALIFY   | one-hot sample seen, counting identical samples
// CAPTURED  | current dwell already captured, waiting for a change
module seven_segment_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    // The counter holds (identical samples - 1), so capture fires when it would step to STABLE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_QUALIFY  = 2'd1;
    localparam logic [1:0] ST_CAPTURED = 2'd2;

    logic [6:0]          seg_in;
    logic [6:0]          seg_q, seg_p_q;
    logic [DIGITS-1:0]   sel_q, sel_p_q;
    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic [4*DIGITS-1:0] slot_q, slot_d;
    logic [DIGITS-1:0]   slot_err_q, slot_err_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   digit_err_q, digit_err_d;
    logic                frame_valid_q;
    logic                same;
    logic                onehot;
    logic                capture;
    logic                mask_full;
    logic [4:0]          dec;

`ifdef SEVEN_SEG_ACTIVE_LOW_EN
    assign seg_in = ~seg;
`else
    assign seg_in = seg;
`endif

    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0111111: r = {1'b0, 4'h0};
            7'b0000110: r = {1'b0, 4'h1};
            7'b1011011: r = {1'b0, 4'h2};
            7'b1001111: r = {1'b0, 4'h3};
            7'b1100110: r = {1'b0, 4'h4};
            7'b1101101: r = {1'b0, 4'h5};
            7'b1111101: r = {1'b0, 4'h6};
            7'b0000111: r = {1'b0, 4'h7};
            7'b1111111: r = {1'b0, 4'h8};
            7'b1101111: r = {1'b0, 4'h9};
            7'b1000000: r = {1'b1, 4'hF};
            default:    r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    assign same      = (seg_q == seg_p_q) && (sel_q == sel_p_q);
    assign onehot    = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
    assign mask_full = &mask_q;
    assign dec       = decode(seg_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!onehot) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (!same) begin
            state_d = ST_QUALIFY;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_QUALIFY: begin
                    if (cnt_q == CNT_CAP) begin
                        capture = 1'b1;
                        state_d = ST_CAPTURED;
                        cnt_d   = CNT_SAT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CAPTURED: begin
                    cnt_d = CNT_SAT;
                end
                default: begin
                    state_d = ST_QUALIFY;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A capture on the frame-completion edge belongs to the next frame.
    always_comb begin
        slot_d      = slot_q;
        slot_err_d  = slot_err_q;
        mask_d      = mask_full ? '0 : mask_q;
        value_d     = value_q;
        digit_err_d = digit_err_q;
        if (capture) begin
            mask_d = mask_d | sel_q;
            for (int i = 0; i < DIGITS; i++) begin
                if (sel_q[i]) begin
                    slot_d[4*i +: 4] = dec[3:0];
                    slot_err_d[i]    = dec[4];
                end
            end
        end
        if (mask_full) begin
            value_d     = slot_q;
            digit_err_d = slot_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q         <= '0;
            seg_p_q       <= '0;
            sel_q         <= '0;
            sel_p_q       <= '0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            mask_q        <= '0;
            slot_q        <= '0;
            slot_err_q    <= '0;
            value_q       <= '0;
            digit_err_q   <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            seg_q         <= seg_in;
            seg_p_q       <= seg_q;
            sel_q         <= dig_sel;
            sel_p_q       <= sel_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            slot_q        <= slot_d;
            slot_err_q    <= slot_err_d;
            value_q       <= value_d;
            digit_err_q   <= digit_err_d;
            frame_valid_q <= mask_full;
        end
    end

    assign value       = value_q;
    assign digit_err   = digit_err_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Randomized and directed bench for seven_segment_reader against a dwell-level reference model.
module tb_seven_segment_reader;

    localparam int DIGITS = 4;
    localparam int SC     = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = '0;
    logic [3:0]  dig_sel = '0;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        frame_valid;

    always #5 clk = ~clk;

    seven_segment_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel),
        .value(value), .digit_err(digit_err), .frame_valid(frame_valid)
    );

    typedef struct {
        logic [15:0] v;
        logic [3:0]  e;
        int          at;
    } frame_t;

    logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                             7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    frame_t      exp_q[$];
    logic [15:0] cur_v = '0;
    logic [3:0]  cur_e = '0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_errv = '0;
    logic [3:0]  m_mask = '0;
    logic [6:0]  last_seg = '0;
    logic [3:0]  last_sel = '0;
    int          run = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int d = 0; d < 10; d++)
            if (s == pat[d]) return {1'b0, d[3:0]};
        if (s == 7'b1000000) return {1'b1, 4'hF};
        return {1'b1, 4'hE};
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (frame_valid) begin
            check("frame_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("frame_time", cyc, exp_q[0].at);
                cur_v = exp_q[0].v;
                cur_e = exp_q[0].e;
                void'(exp_q.pop_front());
            end
        end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            check("frame_missing", frame_valid, 1);
            void'(exp_q.pop_front());
        end
        check("value", value, cur_v);
        check("digit_err", digit_err, cur_e);
    endtask

    // One dwell: pattern s on select sel for hold cycles; identical neighbours extend the same run.
    task automatic dwell(input logic [6:0] s, input logic [3:0] sel, input int hold);
        int prev;
        int idx;
        logic [4:0] d;
        prev = (s == last_seg && sel == last_sel) ? run : 0;
        if ($countones(sel) == 1 && prev < SC && prev + hold >= SC) begin
            idx = 0;
            for (int i = 0; i < DIGITS; i++) if (sel[i]) idx = i;
            d = ref_decode(s);
            m_val[4*idx +: 4] = d[3:0];
            m_errv[idx] = d[4];
            m_mask[idx] = 1'b1;
            if (m_mask == 4'hF) begin
                exp_q.push_back('{v: m_val, e: m_errv, at: cyc + 2 + SC - prev});
                m_mask = '0;
            end
        end
        run = prev + hold;
        last_seg = s;
        last_sel = sel;
`ifdef SEVEN_SEG_ACTIVE_LOW_EN
        seg = ~s;
`else
        seg = s;
`endif
        dig_sel = sel;
        repeat (hold) tick();
    endtask

    task automatic do_reset();
        dwell(7'd0, 4'd0, 3);
        check("pending_before_reset", exp_q.size(), 0);
        rst_n = 1'b0;
        seg = 7'($urandom);
        dig_sel = 4'($urandom);
        #1;
        check("rst_value", value, 0);
        check("rst_digit_err", digit_err, 0);
        check("rst_frame_valid", frame_valid, 0);
        exp_q.delete();
        m_mask = '0;
        m_val = '0;
        m_errv = '0;
        cur_v = '0;
        cur_e = '0;
        tick();
        seg = '0;
        dig_sel = '0;
        rst_n = 1'b1;
        last_seg = '0;
        last_sel = '0;
        run = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] s;
        logic [3:0] sel;
        int h;
        int r;

        seg = 7'($urandom);
        dig_sel = 4'($urandom);
        repeat (3) tick();
        check("init_frame_valid", frame_valid, 0);
        seg = '0;
        dig_sel = '0;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) dwell(pat[$urandom_range(0, 9)], 4'(1 << $urandom_range(0, 3)), 1);

        dwell(pat[3], 4'b1000, 5);
        dwell(pat[2], 4'b0100, 5);
        dwell(pat[1], 4'b0010, 5);
        dwell(pat[0], 4'b0001, 5);
        dwell(7'd0, 4'd0, 4);
        check("nominal_value", value, 16'h3210);
        check("nominal_err", digit_err, 4'b0000);

        dwell(pat[7], 4'b0001, 2);
        dwell(pat[6], 4'b0010, 2);
        dwell(pat[4], 4'b1000, 3);
        dwell(pat[5], 4'b0100, 3);
        dwell(pat[6], 4'b0010, 3);
        dwell(pat[9], 4'b0001, 20);
        dwell(pat[1], 4'b1000, 4);
        dwell(pat[2], 4'b0100, 4);
        dwell(pat[3], 4'b0010, 4);
        do_reset();

        dwell(pat[8], 4'b1000, 4);
        dwell(7'b0101010, 4'b0100, 4);
        dwell(7'b1000000, 4'b0010, 4);
        dwell(pat[8], 4'b0001, 4);
        dwell(7'd0, 4'd0, 4);
        check("err_value", value, 16'h8EF8);
        check("err_flags", digit_err, 4'b0110);

        dwell(pat[1], 4'b0000, 10);
        dwell(pat[1], 4'b0011, 10);
        dwell(pat[5], 4'b0001, 4);
        dwell(pat[1], 4'b1000, 4);
        dwell(pat[9], 4'b0001, 4);
        dwell(pat[2], 4'b0100, 4);
        dwell(pat[3], 4'b0010, 4);
        dwell(7'd0, 4'd0, 4);
        check("overwrite_value", value, 16'h1239);

        dwell(pat[4], 4'b1000, 4);
        dwell(pat[3], 4'b0100, 4);
        dwell(pat[2], 4'b0010, 4);
        do_reset();
        dwell(pat[1], 4'b0001, 4);
        dwell(7'd0, 4'd0, 6);
        check("post_reset_no_frame", value, 16'h0000);
        dwell(pat[4], 4'b1000, 4);
        dwell(pat[3], 4'b0100, 4);
        dwell(pat[2], 4'b0010, 4);
        dwell(pat[1], 4'b0001, 4);
        dwell(7'd0, 4'd0, 4);
        check("post_reset_frame", value, 16'h4321);

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 39);
            if (r == 0) begin
                do_reset();
            end else if (r < 5) begin
                dwell(last_seg, last_sel, $urandom_range(1, 4));
            end else begin
                r = $urandom_range(0, 9);
                sel = (r < 7) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
                r = $urandom_range(0, 9);
                s = (r < 7) ? pat[$urandom_range(0, 9)] : (r == 7) ? 7'b1000000 : 7'($urandom);
                h = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 5);
                dwell(s, sel, h);
            end
        end

        dwell(7'd0, 4'd0, 6);
        check("frames_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
